// File: rtl/multicore_io_pkg.sv
// Shared defaults, core-ID width helper and FIFO entry layout for the multicore I/O hub.
package multicore_io_pkg;

    localparam int unsigned NCORES_DEFAULT = 43;
    localparam int unsigned DW_DEFAULT     = 31;
    localparam int unsigned REQ_W_DEFAULT  = 4;

    // Width of a core index; a single-core hub still carries a 1-bit id.
    function automatic int unsigned core_id_width(input int unsigned ncores);
        return (ncores <= 1) ? 1 : $clog2(ncores);
    endfunction

    localparam int unsigned ID_W_DEFAULT = core_id_width(NCORES_DEFAULT);

    // One merged output entry at the default core count and word width.
    typedef struct packed {
        logic [ID_W_DEFAULT-1:0] id;
        logic [DW_DEFAULT-1:0]   data;
    } fifo_entry_t;

endpackage

// File: rtl/multicore_io_hub_if.sv
// Bundle of sample-source, per-core and sink signals around the multicore I/O hub.
interface multicore_io_hub_if
    import multicore_io_pkg::*;
#(
    parameter int unsigned NCORES = NCORES_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned REQ_W  = REQ_W_DEFAULT
);
    localparam int unsigned ID_W = core_id_width(NCORES);

    logic signed [DW-1:0]       in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [DW-1:0]       core_in;
    logic [NCORES*REQ_W-1:0]    req_in;
    logic [NCORES*DW-1:0]       io_out;
    logic [NCORES*REQ_W-1:0]    out_en;
    logic signed [DW-1:0]       out_data;
    logic [ID_W-1:0]            out_id;
    logic                       out_valid;
    logic                       out_ready;
    logic                       underflow;
    logic                       overrun;
    logic [15:0]                drop_cnt;

    // Environment side: sample source, core array and output sink.
    modport master (
        output in_data, in_valid, req_in, io_out, out_en, out_ready,
        input  in_ready, core_in, out_data, out_id, out_valid,
               underflow, overrun, drop_cnt
    );

    // Hub side.
    modport slave (
        input  in_data, in_valid, req_in, io_out, out_en, out_ready,
        output in_ready, core_in, out_data, out_id, out_valid,
               underflow, overrun, drop_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/multicore_io_hub.sv
// Broadcasts held ADC samples to all cores and merges per-core outputs into one
// round-robin-arbitrated, FIFO-buffered stream tagged with the core index.
module multicore_io_hub
    import multicore_io_pkg::*;
#(
    parameter int unsigned NCORES     = NCORES_DEFAULT,
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned REQ_W      = REQ_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicore_io_hub_if.slave bus
);
    localparam int unsigned ID_W  = core_id_width(NCORES);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   data;
    } hub_entry_t;

    logic                 any_req;
    logic signed [DW-1:0] sample_q;
    logic                 underflow_q;
    logic                 overrun_q;
    logic [15:0]          drop_cnt_q;
    logic [16:0]          drop_sum;
    logic [6:0]           drop_num;

    logic [NCORES-1:0]    pend_q;
    logic [DW-1:0]        data_q [NCORES];
    logic [NCORES-1:0]    en_vec;
    logic [NCORES-1:0]    gnt_vec;
    logic [NCORES-1:0]    load_vec;
    logic [NCORES-1:0]    drop_vec;

    logic [ID_W-1:0]      rr_ptr;
    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_idx;
    int unsigned          cand;
    logic [ID_W-1:0]      cand_idx;

    hub_entry_t           push_entry;
    hub_entry_t           head_entry;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    // ---------------- input broadcast path ----------------
    assign any_req      = |bus.req_in;
    assign bus.in_ready = any_req && bus.in_valid && !rst;
    assign bus.core_in  = sample_q;
    assign bus.underflow = underflow_q;

    // Hold the broadcast sample; load on consumption, flag requests that find no sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                sample_q <= bus.in_data;
            end
            if (any_req && !bus.in_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // ---------------- per-core capture ----------------
    // Per-core capture decision: a slot accepts a new word when empty or being drained now.
    always_comb begin
        en_vec   = '0;
        gnt_vec  = '0;
        load_vec = '0;
        drop_vec = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            en_vec[k]   = |bus.out_en[k*REQ_W +: REQ_W];
            gnt_vec[k]  = gnt_vld && (gnt_idx == ID_W'(k));
            load_vec[k] = en_vec[k] && (!pend_q[k] || gnt_vec[k]);
            drop_vec[k] = en_vec[k] && pend_q[k] && !gnt_vec[k];
        end
    end

    // Capture core words into their holding slots.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NCORES; k++) begin
            if (load_vec[k]) begin
                data_q[k] <= bus.io_out[k*DW +: DW];
            end
        end
    end

    // Count words lost this cycle; several cores may overrun at once.
    always_comb begin
        drop_num = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            drop_num = drop_num + 7'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_cnt_q} + 17'(drop_num);
    end

    // Sticky overrun flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else if (|drop_vec) begin
            overrun_q  <= 1'b1;
            drop_cnt_q <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end

    assign bus.overrun  = overrun_q;
    assign bus.drop_cnt = drop_cnt_q;

    // ---------------- round-robin arbiter ----------------
    // Pick the first pending core at or after rr_ptr, wrapping, when the FIFO can take it.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (!fifo_full || fifo_pop) begin
            for (int unsigned i = 0; i < NCORES; i++) begin
                cand = i + 32'(rr_ptr);
                if (cand >= NCORES) begin
                    cand = cand - NCORES;
                end
                cand_idx = ID_W'(cand);
                if (!gnt_vld && pend_q[cand_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
    end

    // Pending bits and round-robin pointer; a same-cycle reload keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            rr_ptr <= '0;
        end else begin
            pend_q <= (pend_q & ~gnt_vec) | load_vec;
            if (gnt_vld) begin
                rr_ptr <= (gnt_idx == ID_W'(NCORES - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end
    end

    // ---------------- output FIFO ----------------
    assign push_entry.id   = gnt_idx;
    assign push_entry.data = data_q[gnt_idx];
    assign fifo_push       = gnt_vld;
    assign fifo_pop        = !fifo_empty && bus.out_ready;

    sync_fifo #(
        .WIDTH ($bits(hub_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head_entry.data;
    assign bus.out_id    = head_entry.id;

    // Occupancy sanity: the arbiter never overfills the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= CNT_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_multicore_io_hub.sv
// Scoreboard bench for multicore_io_hub: directed scenarios plus random traffic
// checked against a cycle-level reference of the hub's behaviour.
module tb_multicore_io_hub;
    import multicore_io_pkg::*;

    localparam int unsigned NC  = 43;
    localparam int unsigned DW  = 31;
    localparam int unsigned RW  = 4;
    localparam int unsigned FD  = 16;
    localparam int unsigned IDW = core_id_width(NC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicore_io_hub_if #(.NCORES(NC), .DW(DW), .REQ_W(RW)) bus ();

    multicore_io_hub #(
        .NCORES     (NC),
        .DW         (DW),
        .REQ_W      (RW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // expected output stream, oldest first
    fifo_entry_t sb_q[$];

    // reference state: what the hub should hold after the most recent edge
    bit            m_init = 1'b0;
    logic [DW-1:0] m_sample;
    bit            m_under;
    bit            m_over;
    int unsigned   m_drop;
    bit            m_pend [NC];
    logic [DW-1:0] m_word [NC];
    int unsigned   m_rr;
    int unsigned   m_cnt;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit m_busy();
        for (int k = 0; k < NC; k++) if (m_pend[k]) return 1'b1;
        return (m_cnt != 0);
    endfunction

    // Reference model: check visible state, then advance one clock using the inputs now applied.
    initial begin : ref_model
        int            g;
        int            drops;
        int            c;
        bit            pop;
        bit            any_req;
        fifo_entry_t   e;
        forever begin
            @(negedge clk);
            any_req = (bus.req_in != '0);
            if (m_init) begin
                check("in_ready", 64'(bus.in_ready), 64'(!rst && any_req && bus.in_valid));
                check("core_in", 64'(unsigned'(bus.core_in)), 64'(m_sample));
                check("underflow", 64'(bus.underflow), 64'(m_under));
                check("overrun", 64'(bus.overrun), 64'(m_over));
                check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
                check("out_valid", 64'(bus.out_valid), 64'(m_cnt != 0));
                if (m_cnt == 0) begin
                    check("idle_out_data", 64'(unsigned'(bus.out_data)), 64'(0));
                    check("idle_out_id", 64'(bus.out_id), 64'(0));
                end
            end
            if (rst) begin
                m_sample = '0;
                m_under  = 1'b0;
                m_over   = 1'b0;
                m_drop   = 0;
                m_rr     = 0;
                m_cnt    = 0;
                for (int k = 0; k < NC; k++) m_pend[k] = 1'b0;
                sb_q.delete();
                m_init = 1'b1;
            end else begin
                if (any_req && bus.in_valid) m_sample = bus.in_data;
                if (any_req && !bus.in_valid) m_under = 1'b1;
                pop = (m_cnt > 0) && bus.out_ready;
                // the oldest-waiting-in-rotation core leaves first, freeing its slot
                g = -1;
                if (m_cnt < FD || pop) begin
                    for (int i = 0; i < NC; i++) begin
                        c = (int'(m_rr) + i) % NC;
                        if (m_pend[c]) begin
                            g = c;
                            break;
                        end
                    end
                end
                if (g >= 0) begin
                    e.id   = IDW'(g);
                    e.data = m_word[g];
                    sb_q.push_back(e);
                    m_pend[g] = 1'b0;
                    m_rr  = (g + 1) % NC;
                    m_cnt = m_cnt + 1;
                end
                // new words land in empty slots; a word arriving at a full slot is lost
                drops = 0;
                for (int k = 0; k < NC; k++) begin
                    if (bus.out_en[k*RW +: RW] != '0) begin
                        if (!m_pend[k]) begin
                            m_pend[k] = 1'b1;
                            m_word[k] = bus.io_out[k*DW +: DW];
                        end else begin
                            drops++;
                        end
                    end
                end
                if (pop) m_cnt = m_cnt - 1;
                if (drops > 0) begin
                    m_over = 1'b1;
                    m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
                end
            end
        end
    end

    // Monitor: every accepted head word must match the next expected entry.
    initial begin : monitor
        fifo_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got id %0d data %0h, expected no output at %0t",
                             bus.out_id, bus.out_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_id", 64'(bus.out_id), 64'(e.id));
                    check("out_data", 64'(unsigned'(bus.out_data)), 64'(e.data));
                end
            end
        end
    end

    task automatic idle();
        bus.req_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.io_out    = '0;
        bus.out_en    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input int k, input logic [DW-1:0] w);
        bus.out_en[k*RW +: RW] = RW'(1);
        bus.io_out[k*DW +: DW] = w;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        idle();
        tick(2);
        while ((m_busy() || bus.out_valid || sb_q.size() != 0) && waited < 300) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited < 300) n_pass++;
        else $display("FAIL drain_timeout: got %0d words still queued, expected 0", sb_q.size());
    endtask

    initial begin : driver
        logic [DW-1:0] neg5;
        logic [31:0]   r;
        neg5 = DW'(-5);
        idle();
        tick(3);
        do_reset();

        // request with a valid sample: consumed this cycle, broadcast next cycle
        bus.req_in[3*RW +: RW] = RW'(1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(-5);
        #1;
        check("t1_in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        idle();
        check("t1_core_in", 64'(unsigned'(bus.core_in)), 64'(neg5));

        // request without a sample: nothing consumed, underflow sticks
        bus.req_in[10*RW +: RW] = RW'(9);
        #1;
        check("t2_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        idle();
        check("t2_core_in", 64'(unsigned'(bus.core_in)), 64'(neg5));
        tick(3);
        check("t2_underflow", 64'(bus.underflow), 64'(1));

        // single core output: visible two edges later
        pulse(7, DW'(123));
        tick();
        idle();
        check("t3_valid_early", 64'(bus.out_valid), 64'(0));
        tick();
        check("t3_valid", 64'(bus.out_valid), 64'(1));
        check("t3_data", 64'(unsigned'(bus.out_data)), 64'(123));
        check("t3_id", 64'(bus.out_id), 64'(7));
        drain();

        // three simultaneous outputs leave in rotation order on consecutive cycles
        do_reset();
        pulse(0, DW'(11));
        pulse(5, DW'(55));
        pulse(42, DW'(4242));
        tick();
        idle();
        tick();
        check("t4_id0", 64'(bus.out_id), 64'(0));
        tick();
        check("t4_id5", 64'(bus.out_id), 64'(5));
        tick();
        check("t4_id42", 64'(bus.out_id), 64'(42));
        drain();

        // stalled sink: 16 words fill the FIFO, the 17th waits without loss
        do_reset();
        for (int i = 0; i < 17; i++) begin
            idle();
            bus.out_ready = 1'b0;
            r = $urandom();
            pulse(i, r[DW-1:0]);
            tick();
        end
        idle();
        bus.out_ready = 1'b0;
        tick(3);
        check("t5_head_id", 64'(bus.out_id), 64'(0));
        drain();
        check("t5_no_drops", 64'(bus.drop_cnt), 64'(0));

        // a second word from a blocked core is dropped, the first survives
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            bus.out_ready = 1'b0;
            pulse(10 + i, DW'(1000 + i));
            tick();
        end
        idle();
        bus.out_ready = 1'b0;
        pulse(2, DW'(222));
        tick();
        idle();
        bus.out_ready = 1'b0;
        pulse(2, DW'(333));
        tick();
        idle();
        bus.out_ready = 1'b0;
        tick(2);
        check("t6_overrun", 64'(bus.overrun), 64'(1));
        check("t6_drop_cnt", 64'(bus.drop_cnt), 64'(1));
        drain();

        // random traffic with occasional mid-stream resets
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            idle();
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_in[$urandom_range(0, NC-1)*RW +: RW] = RW'($urandom_range(1, 15));
            end
            bus.in_valid = $urandom_range(0, 1) == 1;
            r = $urandom();
            bus.in_data = r[DW-1:0];
            for (int k = 0; k < NC; k++) begin
                if ($urandom_range(0, 19) == 0) begin
                    bus.out_en[k*RW +: RW] = RW'($urandom_range(1, 15));
                    r = $urandom();
                    bus.io_out[k*DW +: DW] = r[DW-1:0];
                end
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        rst = 1'b0;
        drain();

        // every core firing into a stalled sink drives the drop counter to saturation
        do_reset();
        for (int cyc = 0; cyc < 1600; cyc++) begin
            idle();
            bus.out_ready = 1'b0;
            for (int k = 0; k < NC; k++) begin
                r = $urandom();
                pulse(k, r[DW-1:0]);
            end
            tick();
        end
        idle();
        bus.out_ready = 1'b0;
        tick();
        check("t8_drop_sat", 64'(bus.drop_cnt), 64'(16'hFFFF));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_io_hub.md
# multicore_io_hub

Parametrised I/O hub between the ADC sample stream and an array of NCORES processor cores. It broadcasts one held input sample to all cores and advances to the next sample whenever any core requests input. It captures each core's output word on its output-enable and merges all core outputs through a round-robin arbiter into one FIFO-buffered stream tagged with the core index. It sits between the multicore array and the sample source/sink, and replaces per-core ad-hoc file I/O.

## Interface
- `NCORES`, 43: number of cores (1..64)
- `DW`, 31: sample/output word width, signed
- `REQ_W`, 4: width of each core's req_in / out_en field
- `FIFO_DEPTH`, 16: output FIFO entries, power of two ≥ 2
- `clk` input 1: sole clock
- `rst` input 1: synchronous, active-high reset
- `in_data` input DW: next sample from source, signed
- `in_valid` input 1: in_data is valid
- `in_ready` output 1: sample consumed this cycle
- `core_in` output DW: broadcast held sample to all cores
- `req_in` input NCORES*REQ_W: core k field [k*REQ_W +: REQ_W]; nonzero = request
- `io_out` input NCORES*DW: core k word [k*DW +: DW]
- `out_en` input NCORES*REQ_W: core k field; nonzero = output valid this cycle
- `out_data` output DW: merged output word
- `out_id` output $clog2(NCORES) (min 1): originating core index
- `out_valid` output 1: FIFO head valid
- `out_ready` input 1: sink accepts head
- `underflow` output 1: sticky; request with no valid input
- `overrun` output 1: sticky; core output lost
- `drop_cnt` output 16: saturating count of lost core outputs

## Operation
- any_req = OR over all req_in fields being nonzero.
- in_ready = any_req && in_valid && !rst. On in_ready, sample_q <= in_data. core_in = sample_q.
- any_req && !in_valid: sample_q held, underflow set.
- Per core k: pend[k] and data_q[k]. If out_en field k is nonzero and pend[k] is clear, or pend[k] is being granted this cycle: data_q[k] <= io_out[k], pend[k] <= 1.
- Otherwise, out_en while pend[k] is set and not granted: new word discarded, overrun set, drop_cnt += 1 (saturates at 0xFFFF).
- Arbiter: one grant per cycle among pend bits. Search starts at rr_ptr; after grant of k, rr_ptr <= (k+1) mod NCORES.
- Grant allowed when FIFO not full, or when full and a pop occurs this cycle. Granted entry {k, data_q[k]} is pushed and pend[k] is cleared unless reloaded the same cycle.
- FIFO pop on out_valid && out_ready. Push and pop in the same cycle keep the count unchanged.
- Width rules: no arithmetic on data; words pass bit-exact. drop_cnt is unsigned.

## Timing
- Reset values: sample_q/core_in = 0, in_ready = 0, pend = 0, rr_ptr = 0, FIFO empty, out_valid = 0, out_data = 0, out_id = 0, underflow = 0, overrun = 0, drop_cnt = 0.
- Reset mid-operation flushes FIFO and pend contents; pending words are lost and not counted as drops.
- Input path: request at edge t loads sample; core_in shows the new sample after edge t (1-cycle latency).
- Output path, uncontended: out_en in cycle t → pend after edge t → pushed at edge t+1 → out_valid high in cycle t+1 (after edge t+1). Minimum latency is 2 edges.
- Sustained throughput is one word per cycle. With N simultaneous out_en, the last word is granted N−1 cycles later.
- out_data and out_id are stable while out_valid && !out_ready.

## Structure
- Package `multicore_io_pkg` holds:
  - DW and REQ_W defaults
  - function for core-ID width
  - typedef for the FIFO entry struct {id, data}
- Sub-module `sync_fifo`: parametrised width/depth, with full, empty and count.
- Round-robin arbiter stays inline.

## Test plan
- Reset, then req_in core 3 = 4'h1 with in_valid, in_data = -5 → in_ready = 1 that cycle; core_in = -5 next cycle.
- req_in nonzero with in_valid = 0 → in_ready = 0; core_in unchanged; underflow = 1 and stays set.
- Single out_en on core 7 with io_out = 123 → out_valid 2 edges later; out_data = 123; out_id = 7.
- out_en on cores 0, 5 and 42 in one cycle, rr_ptr = 0, out_ready = 1 → ids emitted 0, 5, 42 on consecutive cycles.
- out_ready = 0, 17 single-core out_en pulses on distinct cores with FIFO_DEPTH = 16 → FIFO full; 17th word stays pending; released when out_ready rises; no drops.
- Core 2 pulses out_en twice while its pend bit is blocked by a full FIFO → overrun = 1; drop_cnt = 1; first word delivered intact.
